grad_bram_seq: RTL and testbench

// Gradient playback sequencer, directly upstream of the OCRA1 SPI interface. Reads 32-bit

---
 rtl/ocra_grad_pkg.sv | 31 +++
 rtl/grad_bram_seq_if.sv | 29 ++
 rtl/grad_tick_timer.sv | 26 ++
 rtl/grad_bram_seq.sv | 134 +++++++++++++
 tb/tb_grad_bram_seq.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ocra_grad_pkg.sv
// Shared definitions for the OCRA1 gradient playback path: word field layout and
// sequencer state encoding.
package ocra_grad_pkg;

  localparam int unsigned CH_MSB    = 26;
  localparam int unsigned CH_LSB    = 25;
  localparam int unsigned BCAST_BIT = 24;
  localparam int unsigned PAYLOAD_W = 24;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StFetch,
    StCapt,
    StHold,
    StDone
  } grad_state_e;

  function automatic logic is_bcast(input logic [31:0] word);
    return word[BCAST_BIT];
  endfunction

  function automatic logic [1:0] word_channel(input logic [31:0] word);
    return word[CH_MSB:CH_LSB];
  endfunction

  function automatic logic [PAYLOAD_W-1:0] word_payload(input logic [31:0] word);
    return word[PAYLOAD_W-1:0];
  endfunction

endpackage

// File: rtl/grad_bram_seq_if.sv
// BRAM read port plus serialiser data/valid/busy handshake of the gradient sequencer.
interface grad_bram_seq_if #(
  parameter int unsigned ADDR_W = 10
);
  logic [ADDR_W-1:0] bram_addr_o;
  logic              bram_en_o;
  logic [31:0]       bram_rdata_i;
  logic [31:0]       data_o;
  logic              valid_o;
  logic              busy_i;

  modport master (
    output bram_addr_o,
    output bram_en_o,
    input  bram_rdata_i,
    output data_o,
    output valid_o,
    input  busy_i
  );

  modport slave (
    input  bram_addr_o,
    input  bram_en_o,
    output bram_rdata_i,
    input  data_o,
    input  valid_o,
    output busy_i
  );
endinterface

// File: rtl/grad_tick_timer.sv
// Free-running update-period counter: one tick every interval_i+1 cycles while run_i is high.
module grad_tick_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_i,
  input  logic        restart_i,
  input  logic [15:0] interval_i,
  output logic        tick_o
);

  logic [15:0] cnt_q;

  // >= rather than == so a period shortened on the fly cannot strand the counter.
  assign tick_o = run_i && (cnt_q >= interval_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (restart_i) begin
      cnt_q <= '0;
    end else if (run_i) begin
      cnt_q <= (cnt_q >= interval_i) ? '0 : cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/grad_bram_seq.sv
// Gradient playback sequencer: fetches words from BRAM and strobes them to the SPI serialiser,
// paced by the update period and holding broadcast words until the serialiser is idle.
module grad_bram_seq
  import ocra_grad_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned GUARD  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable_i,
  input  logic [ADDR_W-1:0]   end_addr_i,
  input  logic [15:0]         interval_i,
  grad_bram_seq_if.master     bus,
  output logic                done_o,
  output logic                underrun_o
);

  localparam int unsigned GuardW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);

  grad_state_e       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              en_q;
  logic              bram_en_q;
  logic [31:0]       data_q;
  logic [31:0]       hold_q;
  logic              valid_q;
  logic [GuardW-1:0] guard_q;
  logic              done_q;
  logic              underrun_q;
  logic              tick;
  logic              start;
  logic              run;
  logic              last;

  assign start = (state_q == StIdle) && enable_i && !en_q;
  assign run   = (state_q != StIdle) && (state_q != StDone);
  assign last  = (addr_q == end_addr_i);

  // The enable edge launches the first burst itself; the timer restarts in step with it.
  grad_tick_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .run_i      (run),
    .restart_i  (start),
    .interval_i (interval_i),
    .tick_o     (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      en_q       <= 1'b1;  // enable held high across reset is not a fresh edge
      bram_en_q  <= 1'b0;
      data_q     <= '0;
      hold_q     <= '0;
      valid_q    <= 1'b0;
      guard_q    <= '0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      en_q      <= enable_i;
      valid_q   <= 1'b0;
      bram_en_q <= 1'b0;
      if (guard_q != '0) guard_q <= guard_q - 1'b1;
      if (tick && (state_q inside {StFetch, StCapt, StHold})) underrun_q <= 1'b1;

      if (!enable_i && (state_q != StIdle)) begin
        state_q <= StIdle;
        done_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              state_q    <= StFetch;
              addr_q     <= '0;
              underrun_q <= 1'b0;
              bram_en_q  <= 1'b1;
            end
          end
          StWait: begin
            if (tick) begin
              state_q   <= StFetch;
              bram_en_q <= 1'b1;
            end
          end
          StFetch: state_q <= StCapt;
          StCapt: begin
            if (!is_bcast(bus.bram_rdata_i)) begin
              data_q  <= bus.bram_rdata_i;
              valid_q <= 1'b1;
              if (last) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end else begin
                addr_q    <= addr_q + 1'b1;
                state_q   <= StFetch;
                bram_en_q <= 1'b1;
              end
            end else begin
              hold_q  <= bus.bram_rdata_i;
              state_q <= StHold;
            end
          end
          StHold: begin
            if (!bus.busy_i && (guard_q == '0)) begin
              data_q  <= hold_q;
              valid_q <= 1'b1;
              guard_q <= GuardW'(GUARD);
              if (last) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end else begin
                addr_q  <= addr_q + 1'b1;
                state_q <= StWait;
              end
            end
          end
          StDone: ;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.bram_addr_o = addr_q;
  assign bus.bram_en_o   = bram_en_q;
  assign bus.data_o      = data_q;
  assign bus.valid_o     = valid_q;
  assign done_o          = done_q;
  assign underrun_o      = underrun_q;

endmodule

// File: tb/tb_grad_bram_seq.sv
// Directed bench for grad_bram_seq: BRAM model, strobe logger and hand-computed expectations.
module tb_grad_bram_seq;
  import ocra_grad_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [9:0]  end_addr;
  logic [15:0] interval;
  logic        done;
  logic        underrun;

  int n_checks = 0;
  int n_fail   = 0;
  longint cyc = 0;

  logic [31:0] mem [1024];
  longint      vt [$];
  logic [31:0] vd [$];
  longint      et [$];
  longint      ea [$];
  logic        prev_valid = 1'b0;
  logic        b2b_seen = 1'b0;

  grad_bram_seq_if #(.ADDR_W(10)) bus ();

  grad_bram_seq #(.ADDR_W(10), .GUARD(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable_i   (enable),
    .end_addr_i (end_addr),
    .interval_i (interval),
    .bus        (bus),
    .done_o     (done),
    .underrun_o (underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read BRAM: data appears the cycle after the enable.
  always @(posedge clk) begin
    if (bus.bram_en_o) bus.bram_rdata_i <= mem[bus.bram_addr_o];
  end

  always @(negedge clk) begin
    if (bus.valid_o) begin
      vt.push_back(cyc);
      vd.push_back(bus.data_o);
    end
    if (bus.bram_en_o) begin
      et.push_back(cyc);
      ea.push_back(longint'(bus.bram_addr_o));
    end
    if (bus.valid_o && prev_valid) b2b_seen <= 1'b1;
    prev_valid <= bus.valid_o;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    vt.delete();
    vd.delete();
    et.delete();
    ea.delete();
  endtask

  function automatic longint vt_at(input int i);
    return (i < vt.size()) ? vt[i] : -1;
  endfunction

  function automatic logic [31:0] vd_at(input int i);
    return (i < vd.size()) ? vd[i] : 32'hdead_beef;
  endfunction

  function automatic longint et_at(input int i);
    return (i < et.size()) ? et[i] : -1;
  endfunction

  function automatic longint ea_at(input int i);
    return (i < ea.size()) ? ea[i] : -1;
  endfunction

  task automatic load_basic();
    mem[0] = 32'h0000_0111;  // ch0
    mem[1] = 32'h0200_0222;  // ch1
    mem[2] = 32'h0400_0333;  // ch2
    mem[3] = 32'h0700_0444;  // ch3 + broadcast
  endtask

  longint c_drop;

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    end_addr = '0;
    interval = '0;
    bus.busy_i = 1'b0;
    bus.bram_rdata_i = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    run(2);

    check_eq("rst_valid", bus.valid_o, 0);
    check_eq("rst_bram_en", bus.bram_en_o, 0);
    check_eq("rst_addr", bus.bram_addr_o, 0);
    check_eq("rst_data", bus.data_o, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_underrun", underrun, 0);
    rst = 1'b0;
    run(2);

    // Four words, broadcast last. HOLD costs one extra cycle before the last strobe.
    load_basic();
    interval = 16'd99;
    end_addr = 10'd3;
    clear_log();
    enable = 1'b1;
    run(30);
    check_eq("t1_count", vt.size(), 4);
    check_eq("t1_lat", vt_at(0) - et_at(0), 2);
    check_eq("t1_gap01", vt_at(1) - vt_at(0), 2);
    check_eq("t1_gap12", vt_at(2) - vt_at(1), 2);
    check_eq("t1_gap23", vt_at(3) - vt_at(2), 3);
    check_eq("t1_d0", vd_at(0), 32'h0000_0111);
    check_eq("t1_d1", vd_at(1), 32'h0200_0222);
    check_eq("t1_d2", vd_at(2), 32'h0400_0333);
    check_eq("t1_d3", vd_at(3), 32'h0700_0444);
    check_eq("t1_done", done, 1);
    check_eq("t1_underrun", underrun, 0);
    check_eq("t1_hold_data", bus.data_o, 32'h0700_0444);
    run(20);
    check_eq("t1_no_more_valid", vt.size(), 4);
    enable = 1'b0;
    run(1);
    check_eq("t1_done_clear", done, 0);
    run(2);

    // Eight words in two bursts split by broadcasts at 3 and 7.
    for (int i = 0; i < 8; i++) mem[i] = 32'h0000_1000 + i;
    mem[3] = 32'h0100_1003;
    mem[7] = 32'h0100_1007;
    interval = 16'd49;
    end_addr = 10'd7;
    clear_log();
    enable = 1'b1;
    run(90);
    check_eq("t2_count", vt.size(), 8);
    check_eq("t2_fetch_count", et.size(), 8);
    check_eq("t2_period", et_at(4) - et_at(0), 50);
    check_eq("t2_addr4", ea_at(4), 4);
    check_eq("t2_d7", vd_at(7), 32'h0100_1007);
    check_eq("t2_underrun", underrun, 0);
    check_eq("t2_done", done, 1);
    enable = 1'b0;
    run(2);

    // Broadcast held while the serialiser is busy.
    load_basic();
    interval = 16'd99;
    end_addr = 10'd3;
    bus.busy_i = 1'b1;
    clear_log();
    enable = 1'b1;
    run(30);
    check_eq("t3_held", vt.size(), 3);
    bus.busy_i = 1'b0;
    c_drop = cyc;
    run(3);
    check_eq("t3_count", vt.size(), 4);
    check_eq("t3_when", vt_at(3), c_drop + 1);
    check_eq("t3_data", vd_at(3), 32'h0700_0444);
    enable = 1'b0;
    run(2);

    // Back-to-back broadcasts at interval 0: guard spaces them, underrun flags.
    mem[0] = 32'h0100_0AAA;
    mem[1] = 32'h0300_0BBB;
    interval = 16'd0;
    end_addr = 10'd1;
    clear_log();
    enable = 1'b1;
    run(20);
    check_eq("t4_count", vt.size(), 2);
    check_eq("t4_guard_min", (vt_at(1) - vt_at(0)) >= 4, 1);
    check_eq("t4_gap", vt_at(1) - vt_at(0), 5);
    check_eq("t4_d1", vd_at(1), 32'h0300_0BBB);
    check_eq("t4_underrun", underrun, 1);
    enable = 1'b0;
    run(2);

    // Enable dropped while holding a broadcast.
    load_basic();
    interval = 16'd99;
    end_addr = 10'd3;
    bus.busy_i = 1'b1;
    clear_log();
    enable = 1'b1;
    run(15);
    enable = 1'b0;
    run(1);
    bus.busy_i = 1'b0;
    check_eq("t5_valid_after_drop", bus.valid_o, 0);
    run(10);
    check_eq("t5_discarded", vt.size(), 3);
    check_eq("t5_fetches", et.size(), 4);
    check_eq("t5_done", done, 0);
    clear_log();
    enable = 1'b1;
    run(12);
    check_eq("t5_restart_addr", ea_at(0), 0);
    check_eq("t5_restart_data", vd_at(0), 32'h0000_0111);
    enable = 1'b0;
    run(2);

    // Asynchronous reset mid-burst.
    clear_log();
    enable = 1'b1;
    run(5);
    #1 rst = 1'b1;
    #1;
    check_eq("t6_bram_en", bus.bram_en_o, 0);
    check_eq("t6_valid", bus.valid_o, 0);
    check_eq("t6_data", bus.data_o, 0);
    check_eq("t6_addr", bus.bram_addr_o, 0);
    run(2);
    rst = 1'b0;
    clear_log();
    run(20);
    check_eq("t6_no_restart", vt.size(), 0);
    enable = 1'b0;
    run(2);
    enable = 1'b1;
    run(4);
    check_eq("t6_fresh_edge", vd_at(0), 32'h0000_0111);
    enable = 1'b0;
    run(2);

    // Single word at address 0.
    mem[0] = 32'h0000_0555;
    end_addr = 10'd0;
    clear_log();
    enable = 1'b1;
    run(10);
    check_eq("t7_count", vt.size(), 1);
    check_eq("t7_data", vd_at(0), 32'h0000_0555);
    check_eq("t7_done", done, 1);
    check_eq("no_back_to_back", b2b_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
